// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage instruction/control bundle and fetch enables for pipe_hazard_ctrl.
// PIPE_FWD_EN adds the EX-aligned forwarding selects fwd_a/fwd_b.
interface pipe_hazard_ctrl_if;
  logic [31:0] id_ins;
  logic        id_regwrite;
  logic        id_memtoreg;
  logic        id_regdst;
  logic        id_ew;
  logic        id_pcsrc;
  logic        br_taken;
  logic        pc_en;
  logic        b1_en;
  logic        b1_flush;
  logic        b2_bubble;
`ifdef PIPE_FWD_EN
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;

  modport master (
    input  id_ins, id_regwrite, id_memtoreg,
    input  id_regdst, id_ew, id_pcsrc, br_taken,
    output pc_en, b1_en, b1_flush, b2_bubble,
    output fwd_a, fwd_b
  );

  modport slave (
    output id_ins, id_regwrite, id_memtoreg,
    output id_regdst, id_ew, id_pcsrc, br_taken,
    input  pc_en, b1_en, b1_flush, b2_bubble,
    input  fwd_a, fwd_b
  );
`else
  modport master (
    input  id_ins, id_regwrite, id_memtoreg,
    input  id_regdst, id_ew, id_pcsrc, br_taken,
    output pc_en, b1_en, b1_flush, b2_bubble
  );

  modport slave (
    output id_ins, id_regwrite, id_memtoreg,
    output id_regdst, id_ew, id_pcsrc, br_taken,
    input  pc_en, b1_en, b1_flush, b2_bubble
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// RAW/branch sequencing for the 5-stage MIPS pipeline (PC, buffer1, buffer2).
// Define PIPE_FWD_EN to add EX/MEM forwarding selects and reduce stalls.
module pipe_hazard_ctrl #(
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_ctrl_if.master bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] d;
    logic       ld;
  } sb_t;

  typedef enum logic [1:0] {
    IDLE,
    BR1,
    BR2
  } state_t;

  state_t     state, state_n;
  sb_t        ex, mem, wb, ex_n;
  logic [4:0] rs, rt, rd, dest;
  logic       rt_use;
  logic       hazard;
  logic       issue;
  logic       stall_inc;
  logic       flush_inc;
  logic       pc_en, b1_en, b1_flush, b2_bubble;

  assign rs     = bus.id_ins[25:21];
  assign rt     = bus.id_ins[20:16];
  assign rd     = bus.id_ins[15:11];
  assign dest   = bus.id_regdst ? rd : rt;
  assign rt_use = bus.id_regdst | bus.id_ew | bus.id_pcsrc;

  function automatic logic src_hit(sb_t e, logic [4:0] a,
                                   logic [4:0] b, logic bu);
    return e.v && ((a != 5'd0 && e.d == a) ||
                   (bu && b != 5'd0 && e.d == b));
  endfunction

  logic ex_hit, mem_hit, wb_hit;
  assign ex_hit  = src_hit(ex, rs, rt, rt_use);
  assign mem_hit = src_hit(mem, rs, rt, rt_use);
  assign wb_hit  = src_hit(wb, rs, rt, rt_use) && !WB_BYPASS;

`ifdef PIPE_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign hazard = (ex_hit && ex.ld) || wb_hit;
  logic unused_mem_hit;
  assign unused_mem_hit = mem_hit;
`else
  assign hazard = ex_hit || mem_hit || wb_hit;
`endif

  always_comb begin
    state_n   = state;
    pc_en     = 1'b1;
    b1_en     = 1'b1;
    b1_flush  = 1'b0;
    b2_bubble = 1'b0;
    issue     = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (hazard) begin
          pc_en     = 1'b0;
          b1_en     = 1'b0;
          b2_bubble = 1'b1;
          stall_inc = 1'b1;
        end else if (bus.id_pcsrc) begin
          issue    = 1'b1;
          pc_en    = 1'b0;
          b1_flush = 1'b1;
          state_n  = BR1;
        end else begin
          issue = 1'b1;
        end
      end
      BR1: begin
        pc_en     = 1'b0;
        b1_flush  = 1'b1;
        b2_bubble = 1'b1;
        state_n   = BR2;
      end
      BR2: begin
        b2_bubble = 1'b1;
        b1_flush  = bus.br_taken;
        flush_inc = bus.br_taken;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.pc_en     = pc_en;
  assign bus.b1_en     = b1_en;
  assign bus.b1_flush  = b1_flush;
  assign bus.b2_bubble = b2_bubble;

  always_comb begin
    ex_n = '0;
    if (issue) begin
      ex_n.v  = bus.id_regwrite && dest != 5'd0;
      ex_n.d  = dest;
      ex_n.ld = bus.id_memtoreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ex    <= '0;
      mem   <= '0;
      wb    <= '0;
    end else begin
      state <= state_n;
      ex    <= ex_n;
      mem   <= ex;
      wb    <= mem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

`ifdef PIPE_FWD_EN
  // Newest producer wins: EX (buffer3 ALU) before MEM (mux4 writeback).
  function automatic logic [1:0] fsel(logic [4:0] r, logic u,
                                      sb_t e, sb_t m);
    if (!u || r == 5'd0)         return 2'b00;
    else if (e.v && e.d == r)    return 2'b01;
    else if (m.v && m.d == r)    return 2'b10;
    else                         return 2'b00;
  endfunction

  logic [1:0] fwd_a, fwd_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else if (issue) begin
      fwd_a <= fsel(rs, 1'b1, ex, mem);
      fwd_b <= fsel(rt, rt_use, ex, mem);
    end else begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end
  end

  assign bus.fwd_a = fwd_a;
  assign bus.fwd_b = fwd_b;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.id_ins[31:26], bus.id_ins[10:0],
                         ex.ld, mem.ld, wb.ld};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; covers both PIPE_FWD_EN builds.
// Counters use CNT_W = 2 so saturation shows up in a short run.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst_n;
  logic [1:0] stall_cnt, flush_cnt;
  int checks;
  int failures;

  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(int s, int t, int d, int f);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(f)};
  endfunction

  function automatic logic [31:0] i_ins(int op, int s, int t, int imm);
    return {6'(op), 5'(s), 5'(t), 16'(imm)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(string tag, logic pc, logic b1,
                      logic fl, logic bub);
    chk({tag, "_pc_en"}, 32'(bus.pc_en), 32'(pc));
    chk({tag, "_b1_en"}, 32'(bus.b1_en), 32'(b1));
    chk({tag, "_b1_flush"}, 32'(bus.b1_flush), 32'(fl));
    chk({tag, "_b2_bubble"}, 32'(bus.b2_bubble), 32'(bub));
  endtask

  task automatic drv(logic [31:0] ins, logic rw, logic mtr,
                     logic rdst, logic ew, logic pcs);
    bus.id_ins      = ins;
    bus.id_regwrite = rw;
    bus.id_memtoreg = mtr;
    bus.id_regdst   = rdst;
    bus.id_ew       = ew;
    bus.id_pcsrc    = pcs;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    drv(32'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.br_taken = 1'b0;
    drv(32'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    outs("reset", 1, 1, 0, 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);
`ifdef PIPE_FWD_EN
    chk("reset_fwd_a", 32'(bus.fwd_a), 0);
    chk("reset_fwd_b", 32'(bus.fwd_b), 0);
`endif
    rst_n = 1'b1;
    step();

    // add $3,$1,$2 ; sub $4,$3,$5
    drv(r_ins(1, 2, 3, 32), 1, 0, 1, 0, 0);
    #1 outs("add_issue", 1, 1, 0, 0);
    step();
    drv(r_ins(3, 5, 4, 34), 1, 0, 1, 0, 0);
`ifdef PIPE_FWD_EN
    #1 outs("sub_issue", 1, 1, 0, 0);
    step();
    drv(32'd0, 0, 0, 0, 0, 0);
    #1;
    chk("sub_fwd_a", 32'(bus.fwd_a), 1);
    chk("sub_fwd_b", 32'(bus.fwd_b), 0);
    chk("sub_stall_cnt", 32'(stall_cnt), 0);
`else
    for (int i = 0; i < 3; i++) begin
      #1 outs("sub_stall", 0, 0, 0, 1);
      step();
    end
    #1 outs("sub_issue", 1, 1, 0, 0);
    step();
    drv(32'd0, 0, 0, 0, 0, 0);
    #1 chk("sub_stall_cnt", 32'(stall_cnt), 3);
`endif
    drain();
`ifdef PIPE_FWD_EN
    chk("bubble_fwd_a", 32'(bus.fwd_a), 0);
`endif

    // lw $3,0($1) ; add $4,$3,$3
    drv(i_ins(35, 1, 3, 0), 1, 1, 0, 0, 0);
    #1 outs("lw_issue", 1, 1, 0, 0);
    step();
    drv(r_ins(3, 3, 4, 32), 1, 0, 1, 0, 0);
`ifdef PIPE_FWD_EN
    #1 outs("lw_use_stall", 0, 0, 0, 1);
    step();
    #1 outs("lw_use_issue", 1, 1, 0, 0);
    step();
    drv(32'd0, 0, 0, 0, 0, 0);
    #1;
    chk("lw_fwd_a", 32'(bus.fwd_a), 2);
    chk("lw_fwd_b", 32'(bus.fwd_b), 2);
    chk("lw_stall_cnt", 32'(stall_cnt), 1);
`else
    for (int i = 0; i < 3; i++) begin
      #1 outs("lw_use_stall", 0, 0, 0, 1);
      step();
    end
    #1 outs("lw_use_issue", 1, 1, 0, 0);
    step();
    drv(32'd0, 0, 0, 0, 0, 0);
    #1 chk("stall_cnt_saturated", 32'(stall_cnt), 3);
`endif
    drain();

    // add $0,$1,$2 ; sub $4,$0,$0
    drv(r_ins(1, 2, 0, 32), 1, 0, 1, 0, 0);
    step();
    drv(r_ins(0, 0, 4, 34), 1, 0, 1, 0, 0);
    #1 outs("zero_reg", 1, 1, 0, 0);
    step();
    drain();

    // addi $8 ; ori $8,$1 (rt is its dest) ; sw $8 (rt is a source)
    drv(i_ins(8, 1, 8, 5), 1, 0, 0, 0, 0);
    step();
    drv(i_ins(13, 1, 8, 7), 1, 0, 0, 0, 0);
    #1 outs("rt_dest_only", 1, 1, 0, 0);
    step();
    drain();
    drv(i_ins(8, 1, 8, 5), 1, 0, 0, 0, 0);
    step();
    drv(i_ins(43, 1, 8, 0), 0, 0, 0, 1, 0);
`ifdef PIPE_FWD_EN
    #1 outs("sw_rt_src", 1, 1, 0, 0);
`else
    #1 outs("sw_rt_src", 0, 0, 0, 1);
`endif
    drain();

    // lw $3 ; beq $3,$4 : hazard beats the branch
    drv(i_ins(35, 1, 3, 0), 1, 1, 0, 0, 0);
    step();
    drv(i_ins(4, 3, 4, 8), 0, 0, 0, 0, 1);
    #1 outs("br_hazard_prio", 0, 0, 0, 1);
    drain();

    // beq taken
    drv(i_ins(4, 1, 2, 12), 0, 0, 0, 0, 1);
    #1 outs("beq_t_id", 0, 1, 1, 0);
    step();
    drv(32'd0, 0, 0, 0, 0, 0);
    #1 outs("beq_t_br1", 0, 1, 1, 1);
    step();
    bus.br_taken = 1'b1;
    #1 outs("beq_t_br2", 1, 1, 1, 1);
    step();
    bus.br_taken = 1'b0;
    #1 outs("beq_t_after", 1, 1, 0, 0);
    chk("beq_t_flush_cnt", 32'(flush_cnt), 1);

    // beq not taken
    drv(i_ins(4, 1, 2, 12), 0, 0, 0, 0, 1);
    #1 outs("beq_nt_id", 0, 1, 1, 0);
    step();
    drv(32'd0, 0, 0, 0, 0, 0);
    #1 outs("beq_nt_br1", 0, 1, 1, 1);
    step();
    #1 outs("beq_nt_br2", 1, 1, 0, 1);
    step();
    #1 outs("beq_nt_after", 1, 1, 0, 0);
    chk("beq_nt_flush_cnt", 32'(flush_cnt), 1);
    drain();

    // reset while in BR1 with add $3 in flight
    drv(r_ins(1, 2, 3, 32), 1, 0, 1, 0, 0);
    step();
    drv(i_ins(4, 1, 2, 12), 0, 0, 0, 0, 1);
    step();
    drv(32'd0, 0, 0, 0, 0, 0);
    #1 outs("rst_br1_pre", 0, 1, 1, 1);
    rst_n = 1'b0;
    #1 outs("rst_br1", 1, 1, 0, 0);
    chk("rst_br1_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_br1_flush_cnt", 32'(flush_cnt), 0);
    step();
    rst_n = 1'b1;
    drv(r_ins(3, 5, 4, 34), 1, 0, 1, 0, 0);
    #1 outs("rst_sb_empty", 1, 1, 0, 0);
    step();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage MIPS pipeline (fetch/ID/EX/MEM/WB with buffers b1..b4).
- Keeps its own 3-deep in-flight scoreboard and detects RAW hazards on the instruction in ID.
- Freezes fetch around conditional branches that resolve in MEM.
- Drives the enables for the PC register, buffer1 and buffer2, so the datapath runs without compiler-inserted NOPs.

Parameters:
- WB_BYPASS, 0: 1 = register bank writes before it reads in the same cycle, so a producer in WB is not a hazard.
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ins  in  32  instruction at buffer1 output (ID stage).
- id_regwrite  in  1  uc regwrite for the ID instruction.
- id_memtoreg  in  1  uc memtoreg; 1 = load.
- id_regdst  in  1  uc regdst; 1 = R-type, dest rd.
- id_ew  in  1  uc ew; 1 = store.
- id_pcsrc  in  1  uc PCSrc; 1 = conditional branch.
- br_taken  in  1  branch AND-gate output (zero & pcsrc from buffer3); valid in state BR2.
- pc_en  out  1  PC load enable.
- b1_en  out  1  buffer1 load enable; 0 = hold.
- b1_flush  out  1  buffer1 loads all-zero NOP.
- b2_bubble  out  1  buffer2 loads zero control bits (regwrite/ew/er/pcsrc = 0).
- stall_cnt  out  CNT_W  cycles stalled on RAW hazards, saturating.
- flush_cnt  out  CNT_W  taken branches, saturating.

Behaviour:
- Field decode:
  - rs = id_ins[25:21], rt = id_ins[20:16], rd = id_ins[15:11].
  - dest = id_regdst ? rd : rt.
  - rs is always a source; rt is a source when id_regdst | id_ew | id_pcsrc.
  - Register 0 is never a source or dest for hazard purposes.
- Scoreboard: entries EX, MEM, WB, each {valid, dest[4:0], load}.
  - Every cycle: WB <= MEM, MEM <= EX.
  - EX <= ID instruction when issued (valid = id_regwrite & dest != 0), else invalid.
  - Reset: all entries invalid.
- Hazard (combinational) when any used source equals the dest of a valid entry in EX or MEM, or in WB when WB_BYPASS = 0.
- States: IDLE, BR1, BR2. Reset state IDLE.
- IDLE, hazard:
  - pc_en = 0, b1_en = 0, b1_flush = 0, b2_bubble = 1.
  - No issue; stall_cnt += 1.
  - A hazard takes priority over a branch in ID.
- IDLE, no hazard, id_pcsrc = 1:
  - Issue; pc_en = 0, b1_en = 1, b1_flush = 1, b2_bubble = 0.
  - Next state BR1. PC holds branch+4.
- IDLE, otherwise: pc_en = 1, b1_en = 1, b1_flush = 0, b2_bubble = 0.
- BR1 (branch in EX): pc_en = 0, b1_en = 1, b1_flush = 1, b2_bubble = 1. Next state BR2.
- BR2 (branch in MEM, br_taken valid): pc_en = 1, b1_en = 1, b2_bubble = 1, b1_flush = br_taken. Next state IDLE.
  - Taken: PC <= target, branch+4 is discarded, flush_cnt += 1.
  - Not taken: branch+4 enters ID.
- ID holds a NOP during BR1/BR2, so no hazard can arise in those states.
- Branch penalty: 2 cycles not taken, 3 cycles taken.
- Counters saturate at all-ones.
- Reset mid-operation: state IDLE, scoreboard cleared, counters 0.
- Reset output values: pc_en = 1, b1_en = 1, b1_flush = 0, b2_bubble = 0, counters 0.

Optional Feature:
- Macro: PIPE_FWD_EN.
- When defined, adds ports fwd_a and fwd_b, out, 2 bits each, registered and aligned with the EX stage (sampled by the ALU operand muxes).
  - Values: 00 = register file, 01 = buffer3 ALU result, 10 = mux4 writeback value.
  - Producer in EX at ID time: select 01.
  - Producer in MEM at ID time: select 10.
  - Hazard reduces to: EX entry is a load and its dest matches a used source (1-cycle stall). A WB producer with WB_BYPASS = 0 still stalls.
  - fwd_a/fwd_b are forced to 00 on bubble; reset value 00.
- When undefined: no fwd ports; full stall rule as in Behaviour.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5, WB_BYPASS = 0: b2_bubble high 3 cycles, pc_en low 3 cycles, sub issues on the 4th cycle, stall_cnt = 3.
- Same sequence with PIPE_FWD_EN: zero stalls; fwd_a = 01 while sub is in EX.
- lw $3,0($1) then add $4,$3,$3 with PIPE_FWD_EN: exactly 1 stall cycle, then fwd_a = fwd_b = 10.
- beq taken at PC 0x10, target 0x40: b1_flush high 3 cycles, next instruction in ID is from 0x40, flush_cnt = 1.
- beq not taken at PC 0x10: 2 flush cycles, then instruction 0x14 in ID, flush_cnt = 0.
- Write to $0 followed by a reader of $0: no stall. Assert rst_n low during BR1: state IDLE, all outputs at reset values, scoreboard empty.
